mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
Parametrised multicycle control unit for the 32-bit MIPS-subset datapath, built as the successor to the fixed-latency control unit. It sequences fetch, decode, execute, memory and writeback, and drives every datapath select and write-enable. New over the previous generation:
- asynchronous reset
- variable-latency memory handshake with a watchdog timeout
- BNE support
- sticky illegal-opcode and memory-error flags

Parameters:
OP_RTYPE, 6'h00, R-type opcode
OP_LW, 6'h23, load word opcode
OP_SW, 6'h2B, store word opcode
OP_BEQ, 6'h04, branch-if-equal opcode
OP_BNE, 6'h05, branch-if-not-equal opcode
OP_ADDI, 6'h08, add-immediate opcode
OP_J, 6'h02, jump opcode
WAIT_MAX, 16, memory wait cycles tolerated before timeout (2..255)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
op  in  6  IR[31:26]
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access requested
id_sel  out  1  address mux: 0 PC, 1 ALUOutR
irwe  out  1  instruction register write
mwe  out  1  memory write
pcwe  out  1  unconditional PC write
br_eq  out  1  PC write if Zero
br_ne  out  1  PC write if !Zero
pc_sel  out  2  00 ALU, 01 ALUOutR, 10 jump target
alu_in1_sel  out  1  0 PC, 1 A
alu_in2_sel  out  2  00 B, 01 const 1, 10 SImm
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
rfd_sel  out  1  0 rt, 1 rd
mto_rf_sel  out  1  0 ALUOutR, 1 DR
rfwe  out  1  register file write
illegal_op  out  1  sticky unknown-opcode flag
mem_err  out  1  sticky memory-timeout flag

Behaviour:
- Reset (async, rst=1): state=FETCH, wait counter=0, illegal_op=0, mem_err=0. All write-enables (irwe, mwe, pcwe, br_eq, br_ne, rfwe) and mem_req are forced 0 while rst=1. All selects are 0.
- Outputs are combinational from the state register plus mem_ready. Any output not listed for a state is 0.
- FETCH: mem_req=1, id_sel=0, alu_in1_sel=0, alu_in2_sel=01, alu_op=00, pc_sel=00. irwe=pcwe=1 only in the cycle mem_ready=1, then go to DECODE. Otherwise hold in FETCH.
- DECODE: alu_in1_sel=0, alu_in2_sel=10, alu_op=00 (branch target into ALUOutR). Next state by op:
  - LW or SW -> MEMADR
  - RTYPE -> EXEC
  - BEQ or BNE -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - any other -> set illegal_op, go to FETCH (instruction skipped)
- MEMADR: alu_in1_sel=1, alu_in2_sel=10, alu_op=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD: mem_req=1, id_sel=1. On mem_ready -> MEMWB.
- MEMWB: rfd_sel=0, mto_rf_sel=1, rfwe=1 -> FETCH.
- MEMWR: mem_req=1, id_sel=1. mwe=1 only in the mem_ready cycle, then -> FETCH.
- EXEC: alu_in1_sel=1, alu_in2_sel=00, alu_op=10 -> ALUWB.
- ALUWB: rfd_sel=1, mto_rf_sel=0, rfwe=1 -> FETCH.
- BRANCH: alu_in1_sel=1, alu_in2_sel=00, alu_op=01, pc_sel=01. br_eq=1 for BEQ, br_ne=1 for BNE -> FETCH.
- ADDIEX: alu_in1_sel=1, alu_in2_sel=10, alu_op=00 -> ADDIWB.
- ADDIWB: rfd_sel=0, mto_rf_sel=0, rfwe=1 -> FETCH.
- JUMP: pc_sel=10, pcwe=1 -> FETCH.
- HALT: all outputs 0; exit only via rst.
- Op is sampled from the IR, which is stable after FETCH. The FSM never reads op in FETCH.
- Watchdog:
  - 8-bit counter increments each cycle in FETCH/MEMRD/MEMWR with mem_req=1 and mem_ready=0.
  - Cleared on mem_ready or on state change.
  - At count == WAIT_MAX-1 with mem_ready still 0: set mem_err, go to HALT, no strobe issued.
  - mem_ready=1 in that same cycle wins: normal completion, no error.
- CPI: R-type/ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3, with zero memory wait states. Each memory wait cycle adds 1.
- Reset mid-instruction aborts it. No partial write may occur after rst rises.

Optional Feature:
MC_CTRL_PERF_EN
- Defined: adds outputs cyc_cnt[31:0] (increments every non-reset cycle, wraps) and instr_cnt[31:0] (increments on each transition into FETCH from a completing state, including the illegal-op skip). Both reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mc_pkg:
  - state enum (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT)
  - alu_op, pc_sel and alu_in2_sel encodings as named constants
  - default opcode constants
- One sub-module, mc_mem_watchdog: the wait counter and timeout compare, outputting timeout.

Test Plan:
- rst=1 asserted mid-MEMWR with mem_ready=0 -> next sample: state=FETCH, mwe=0, rfwe=0, flags=0.
- LW (op=6'h23), mem_ready always 1 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; rfwe=1 only in cycle 5 with mto_rf_sel=1, rfd_sel=0.
- FETCH with mem_ready held low 3 cycles, WAIT_MAX=16 -> irwe/pcwe stay 0 for 3 cycles; pulse once on cycle 4.
- mem_ready stuck 0, WAIT_MAX=4 -> mem_err=1 after 4 FETCH cycles; HALT with all outputs 0 until rst.
- op=6'h05 (BNE) -> BRANCH state with br_ne=1, br_eq=0, alu_op=01, pc_sel=01; op=6'h3F -> illegal_op=1, return to FETCH after DECODE.
- With MC_CTRL_PERF_EN, run 3 R-type instructions, zero wait -> instr_cnt=3, cyc_cnt=12.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control unit: state codes, datapath
// select encodings, default MIPS opcodes and a state-class helper.
package mc_pkg;

  typedef logic [3:0] state_t;

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXEC   = 4'd6;
  localparam logic [3:0] ALUWB  = 4'd7;
  localparam logic [3:0] BRANCH = 4'd8;
  localparam logic [3:0] ADDIEX = 4'd9;
  localparam logic [3:0] ADDIWB = 4'd10;
  localparam logic [3:0] JUMP   = 4'd11;
  localparam logic [3:0] HALT   = 4'd12;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] IN2_B    = 2'b00;
  localparam logic [1:0] IN2_ONE  = 2'b01;
  localparam logic [1:0] IN2_SIMM = 2'b10;

  localparam logic [5:0] DEF_OP_RTYPE = 6'h00;
  localparam logic [5:0] DEF_OP_LW    = 6'h23;
  localparam logic [5:0] DEF_OP_SW    = 6'h2B;
  localparam logic [5:0] DEF_OP_BEQ   = 6'h04;
  localparam logic [5:0] DEF_OP_BNE   = 6'h05;
  localparam logic [5:0] DEF_OP_ADDI  = 6'h08;
  localparam logic [5:0] DEF_OP_J     = 6'h02;

  // States that hold mem_req high and wait on mem_ready.
  function automatic logic is_mem_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/mc_mem_watchdog.sv
// Memory wait watchdog: counts stalled cycles while a memory access is pending
// and flags a timeout on the last tolerated cycle if memory is still not ready.
module mc_mem_watchdog #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  logic [7:0] count_reg;
  logic       stalled;

  assign stalled = active && !mem_ready;
  // mem_ready in the final cycle suppresses the timeout: completion wins.
  assign timeout = stalled && (count_reg == 8'(WAIT_MAX - 1));

  // Any cycle that is not a continuing stall clears the count, which also
  // covers every state change (leaving a wait state needs ready or timeout).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (stalled && !timeout) begin
      count_reg <= count_reg + 8'd1;
    end else begin
      count_reg <= '0;
    end
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-subset control FSM with memory handshake, watchdog and sticky
// error flags. Optional performance counters are enabled by MC_CTRL_PERF_EN.
module mc_ctrl_fsm
  import mc_pkg::*;
#(
  parameter logic [5:0] OP_RTYPE = DEF_OP_RTYPE,
  parameter logic [5:0] OP_LW    = DEF_OP_LW,
  parameter logic [5:0] OP_SW    = DEF_OP_SW,
  parameter logic [5:0] OP_BEQ   = DEF_OP_BEQ,
  parameter logic [5:0] OP_BNE   = DEF_OP_BNE,
  parameter logic [5:0] OP_ADDI  = DEF_OP_ADDI,
  parameter logic [5:0] OP_J     = DEF_OP_J,
  parameter int         WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       id_sel,
  output logic       irwe,
  output logic       mwe,
  output logic       pcwe,
  output logic       br_eq,
  output logic       br_ne,
  output logic [1:0] pc_sel,
  output logic       alu_in1_sel,
  output logic [1:0] alu_in2_sel,
  output logic [1:0] alu_op,
  output logic       rfd_sel,
  output logic       mto_rf_sel,
  output logic       rfwe,
  output logic       illegal_op,
  output logic       mem_err
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] instr_cnt
`endif
);

  state_t state_reg;
  state_t state_next;
  logic   illegal_set;
  logic   timeout;

  mc_mem_watchdog #(
    .WAIT_MAX (WAIT_MAX)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .active    (is_mem_wait_state(state_reg)),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    illegal_set = 1'b0;
    case (state_reg)
      FETCH: begin
        if (timeout) begin
          state_next = HALT;
        end else if (mem_ready) begin
          state_next = DECODE;
        end
      end
      DECODE: begin
        if (op == OP_LW || op == OP_SW) begin
          state_next = MEMADR;
        end else if (op == OP_RTYPE) begin
          state_next = EXEC;
        end else if (op == OP_BEQ || op == OP_BNE) begin
          state_next = BRANCH;
        end else if (op == OP_ADDI) begin
          state_next = ADDIEX;
        end else if (op == OP_J) begin
          state_next = JUMP;
        end else begin
          state_next  = FETCH;
          illegal_set = 1'b1;
        end
      end
      MEMADR: state_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD: begin
        if (timeout) begin
          state_next = HALT;
        end else if (mem_ready) begin
          state_next = MEMWB;
        end
      end
      MEMWR: begin
        if (timeout) begin
          state_next = HALT;
        end else if (mem_ready) begin
          state_next = FETCH;
        end
      end
      MEMWB:  state_next = FETCH;
      EXEC:   state_next = ALUWB;
      ALUWB:  state_next = FETCH;
      BRANCH: state_next = FETCH;
      ADDIEX: state_next = ADDIWB;
      ADDIWB: state_next = FETCH;
      JUMP:   state_next = FETCH;
      HALT:   state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Outputs are gated by rst directly so no strobe can leak out while the
  // asynchronous reset is still being applied.
  always_comb begin
    mem_req     = 1'b0;
    id_sel      = 1'b0;
    irwe        = 1'b0;
    mwe         = 1'b0;
    pcwe        = 1'b0;
    br_eq       = 1'b0;
    br_ne       = 1'b0;
    pc_sel      = PC_ALU;
    alu_in1_sel = 1'b0;
    alu_in2_sel = IN2_B;
    alu_op      = ALU_ADD;
    rfd_sel     = 1'b0;
    mto_rf_sel  = 1'b0;
    rfwe        = 1'b0;
    if (!rst) begin
      case (state_reg)
        FETCH: begin
          mem_req     = 1'b1;
          alu_in2_sel = IN2_ONE;
          alu_op      = ALU_ADD;
          pc_sel      = PC_ALU;
          irwe        = mem_ready;
          pcwe        = mem_ready;
        end
        DECODE: begin
          alu_in2_sel = IN2_SIMM;
          alu_op      = ALU_ADD;
        end
        MEMADR: begin
          alu_in1_sel = 1'b1;
          alu_in2_sel = IN2_SIMM;
          alu_op      = ALU_ADD;
        end
        MEMRD: begin
          mem_req = 1'b1;
          id_sel  = 1'b1;
        end
        MEMWB: begin
          mto_rf_sel = 1'b1;
          rfwe       = 1'b1;
        end
        MEMWR: begin
          mem_req = 1'b1;
          id_sel  = 1'b1;
          mwe     = mem_ready;
        end
        EXEC: begin
          alu_in1_sel = 1'b1;
          alu_in2_sel = IN2_B;
          alu_op      = ALU_FUNCT;
        end
        ALUWB: begin
          rfd_sel = 1'b1;
          rfwe    = 1'b1;
        end
        BRANCH: begin
          alu_in1_sel = 1'b1;
          alu_in2_sel = IN2_B;
          alu_op      = ALU_SUB;
          pc_sel      = PC_ALUOUT;
          br_eq       = (op == OP_BEQ);
          br_ne       = (op == OP_BNE);
        end
        ADDIEX: begin
          alu_in1_sel = 1'b1;
          alu_in2_sel = IN2_SIMM;
          alu_op      = ALU_ADD;
        end
        ADDIWB: begin
          rfwe = 1'b1;
        end
        JUMP: begin
          pc_sel = PC_JUMP;
          pcwe   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_op <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      if (illegal_set) begin
        illegal_op <= 1'b1;
      end
      if (timeout) begin
        mem_err <= 1'b1;
      end
    end
  end

`ifdef MC_CTRL_PERF_EN
  logic instr_done;

  // HALT never returns to FETCH, so every FETCH entry is a retired (or skipped) instruction.
  assign instr_done = (state_next == FETCH) && (state_reg != FETCH) && (state_reg != HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (instr_done) begin
        instr_cnt <= instr_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed corner cases plus randomized instruction
// streams checked cycle by cycle against an instruction-level phase model.
module tb_mc_ctrl_fsm;

  localparam int WAIT_MAX = 4;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
    P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_HALT
  } phase_t;

  typedef struct packed {
    logic       mem_req;
    logic       id_sel;
    logic       irwe;
    logic       mwe;
    logic       pcwe;
    logic       br_eq;
    logic       br_ne;
    logic [1:0] pc_sel;
    logic       alu_in1_sel;
    logic [1:0] alu_in2_sel;
    logic [1:0] alu_op;
    logic       rfd_sel;
    logic       mto_rf_sel;
    logic       rfwe;
  } ctrl_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = 6'h00;
  logic       mem_ready = 1'b0;
  logic       mem_req, id_sel, irwe, mwe, pcwe, br_eq, br_ne;
  logic [1:0] pc_sel, alu_in2_sel, alu_op;
  logic       alu_in1_sel, rfd_sel, mto_rf_sel, rfwe, illegal_op, mem_err;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, instr_cnt;
`endif

  mc_ctrl_fsm #(
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .id_sel      (id_sel),
    .irwe        (irwe),
    .mwe         (mwe),
    .pcwe        (pcwe),
    .br_eq       (br_eq),
    .br_ne       (br_ne),
    .pc_sel      (pc_sel),
    .alu_in1_sel (alu_in1_sel),
    .alu_in2_sel (alu_in2_sel),
    .alu_op      (alu_op),
    .rfd_sel     (rfd_sel),
    .mto_rf_sel  (mto_rf_sel),
    .rfwe        (rfwe),
    .illegal_op  (illegal_op),
    .mem_err     (mem_err)
`ifdef MC_CTRL_PERF_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .instr_cnt   (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  ctrl_t dut_ctrl;
  assign dut_ctrl = {mem_req, id_sel, irwe, mwe, pcwe, br_eq, br_ne, pc_sel,
                     alu_in1_sel, alu_in2_sel, alu_op, rfd_sel, mto_rf_sel, rfwe};

  int   checks = 0;
  int   failures = 0;
  logic exp_illegal = 1'b0;
  logic exp_err = 1'b0;
  int   exp_cyc = 0;
  int   exp_instr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word each phase must present, straight from the state table.
  function automatic ctrl_t exp_ctrl(input phase_t ph, input logic r, input logic [5:0] o);
    ctrl_t c = '0;
    case (ph)
      P_FETCH:  begin c.mem_req = 1; c.alu_in2_sel = 2'b01; c.irwe = r; c.pcwe = r; end
      P_DECODE: c.alu_in2_sel = 2'b10;
      P_MEMADR: begin c.alu_in1_sel = 1; c.alu_in2_sel = 2'b10; end
      P_MEMRD:  begin c.mem_req = 1; c.id_sel = 1; end
      P_MEMWB:  begin c.mto_rf_sel = 1; c.rfwe = 1; end
      P_MEMWR:  begin c.mem_req = 1; c.id_sel = 1; c.mwe = r; end
      P_EXEC:   begin c.alu_in1_sel = 1; c.alu_op = 2'b10; end
      P_ALUWB:  begin c.rfd_sel = 1; c.rfwe = 1; end
      P_BRANCH: begin
        c.alu_in1_sel = 1; c.alu_op = 2'b01; c.pc_sel = 2'b01;
        c.br_eq = (o == OP_BEQ); c.br_ne = (o == OP_BNE);
      end
      P_ADDIEX: begin c.alu_in1_sel = 1; c.alu_in2_sel = 2'b10; end
      P_ADDIWB: c.rfwe = 1;
      P_JUMP:   begin c.pc_sel = 2'b10; c.pcwe = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // One clock: drive mem_ready, check outputs at the falling edge, step past posedge.
  task automatic cycle(input phase_t ph, input logic r);
    ctrl_t e;
    mem_ready = r;
    e = exp_ctrl(ph, r, op);
    @(negedge clk);
    check($sformatf("%s_ctrl", ph.name()), 32'(dut_ctrl), 32'(e));
    check("illegal_op", 32'(illegal_op), 32'(exp_illegal));
    check("mem_err", 32'(mem_err), 32'(exp_err));
`ifdef MC_CTRL_PERF_EN
    check("cyc_cnt", cyc_cnt, 32'(exp_cyc));
    check("instr_cnt", instr_cnt, 32'(exp_instr));
`endif
    @(posedge clk);
    #1;
    exp_cyc++;
  endtask

  task automatic do_reset(input logic r);
    rst = 1'b1;
    mem_ready = r;
    exp_illegal = 1'b0;
    exp_err = 1'b0;
    exp_cyc = 0;
    exp_instr = 0;
    @(negedge clk);
    check("rst_ctrl", 32'(dut_ctrl), 32'd0);
    check("rst_illegal_op", 32'(illegal_op), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
`ifdef MC_CTRL_PERF_EN
    check("rst_cyc_cnt", cyc_cnt, 32'd0);
    check("rst_instr_cnt", instr_cnt, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Memory phase: ready arrives after 'target' stall cycles unless the
  // watchdog budget of WAIT_MAX cycles runs out first.
  task automatic mem_phase(input phase_t ph, input int target, output bit timed_out);
    timed_out = 1'b0;
    for (int w = 0; w < WAIT_MAX; w++) begin
      logic r;
      r = (w == target);
      cycle(ph, r);
      if (r) break;
      if (w == WAIT_MAX - 1) begin
        timed_out = 1'b1;
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic halt_then_reset();
    repeat (3) cycle(P_HALT, 1'($urandom));
    do_reset(1'($urandom));
  endtask

  task automatic run_instr(input logic [5:0] opc, input int wf, input int wm);
    bit to;
    op = 6'($urandom);  // IR not yet loaded; FETCH must ignore op
    mem_phase(P_FETCH, wf, to);
    if (to) begin
      $display("instr op=%02h fetch timeout -> halt", opc);
      halt_then_reset();
      return;
    end
    op = opc;
    cycle(P_DECODE, 1'($urandom));
    if (opc == OP_LW || opc == OP_SW) begin
      cycle(P_MEMADR, 1'($urandom));
      if (opc == OP_LW) begin
        mem_phase(P_MEMRD, wm, to);
        if (!to) cycle(P_MEMWB, 1'($urandom));
      end else begin
        mem_phase(P_MEMWR, wm, to);
      end
      if (to) begin
        $display("instr op=%02h memory timeout -> halt", opc);
        halt_then_reset();
        return;
      end
    end else if (opc == OP_RTYPE) begin
      cycle(P_EXEC, 1'($urandom));
      cycle(P_ALUWB, 1'($urandom));
    end else if (opc == OP_BEQ || opc == OP_BNE) begin
      cycle(P_BRANCH, 1'($urandom));
    end else if (opc == OP_ADDI) begin
      cycle(P_ADDIEX, 1'($urandom));
      cycle(P_ADDIWB, 1'($urandom));
    end else if (opc == OP_J) begin
      cycle(P_JUMP, 1'($urandom));
    end else begin
      exp_illegal = 1'b1;
    end
    exp_instr++;
    $display("instr op=%02h fetch_wait=%0d mem_wait=%0d", opc, wf, wm);
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] legal [7];
    logic [5:0] o;
    legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    if ($urandom_range(7, 0) != 0) return legal[$urandom_range(6, 0)];
    do o = 6'($urandom); while (o inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J});
    return o;
  endfunction

  function automatic int pick_wait();
    if ($urandom_range(9, 0) < 8) return $urandom_range(2, 0);
    return $urandom_range(WAIT_MAX + 1, 0);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit reached checks=%0d", checks);
    $fatal(1, "time limit");
  end

  initial begin
    do_reset(1'b0);

    run_instr(OP_LW, 0, 0);
    run_instr(OP_RTYPE, 3, 0);
    run_instr(OP_SW, 0, WAIT_MAX - 1);
    run_instr(OP_LW, WAIT_MAX - 1, 2);
    run_instr(OP_BNE, 0, 0);
    run_instr(OP_BEQ, 1, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_ADDI, 2, 0);
    run_instr(6'h3F, 0, 0);
    run_instr(OP_RTYPE, 0, 0);
    run_instr(OP_RTYPE, WAIT_MAX + 2, 0);
    run_instr(OP_LW, 0, WAIT_MAX);
    run_instr(OP_SW, 1, WAIT_MAX + 1);

    // Abort a store while it is still waiting on memory.
    op = 6'($urandom);
    cycle(P_FETCH, 1'b1);
    op = OP_SW;
    cycle(P_DECODE, 1'b0);
    cycle(P_MEMADR, 1'b0);
    cycle(P_MEMWR, 1'b0);
    do_reset(1'b0);
    cycle(P_FETCH, 1'b0);
    do_reset(1'b1);

    repeat (3) run_instr(OP_RTYPE, 0, 0);
`ifdef MC_CTRL_PERF_EN
    check("perf_cyc_cnt_3rtype", cyc_cnt, 32'd12);
    check("perf_instr_cnt_3rtype", instr_cnt, 32'd3);
`endif

    for (int i = 0; i < 300; i++) begin
      run_instr(pick_op(), pick_wait(), pick_wait());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
